// File: rtl/alu_issue_unit_if.sv
// Reservation-station issue and CDB result bus for alu_issue_unit.
// The master modport is the issue unit; the slave modport is the surrounding pipeline.
interface alu_issue_unit_if #(
  parameter int unsigned NUM_RS = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ROB_W  = 4
);
  logic                      mispredicted;
  logic [NUM_RS-1:0]         rs_valid;
  logic [3*NUM_RS-1:0]       rs_alu_op;
  logic [ROB_W*NUM_RS-1:0]   rs_rob;
  logic [XLEN*NUM_RS-1:0]    rs_src1;
  logic [XLEN*NUM_RS-1:0]    rs_src2;
  logic [NUM_RS-1:0]         consumed;
  logic                      cdb_req;
  logic                      cdb_grant;
  logic [ROB_W-1:0]          cdb_rob;
  logic [XLEN-1:0]           cdb_result;
  logic                      unit_busy;

  modport master (
    input  mispredicted, rs_valid, rs_alu_op, rs_rob, rs_src1, rs_src2, cdb_grant,
    output consumed, cdb_req, cdb_rob, cdb_result, unit_busy
  );

  modport slave (
    output mispredicted, rs_valid, rs_alu_op, rs_rob, rs_src1, rs_src2, cdb_grant,
    input  consumed, cdb_req, cdb_rob, cdb_result, unit_busy
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Two-stage ALU issue unit: round-robin pick from reservation stations,
// E1 operand capture, E2 result register held until the CDB grants it.
module alu_issue_unit #(
  parameter int unsigned NUM_RS = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ROB_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_unit_if.master bus
);
  localparam int unsigned PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  logic [2:0]       op_arr   [NUM_RS];
  logic [ROB_W-1:0] rob_arr  [NUM_RS];
  logic [XLEN-1:0]  src1_arr [NUM_RS];
  logic [XLEN-1:0]  src2_arr [NUM_RS];

  for (genvar g = 0; g < NUM_RS; g++) begin : g_unpack
    assign op_arr[g]   = bus.rs_alu_op[3*g +: 3];
    assign rob_arr[g]  = bus.rs_rob[ROB_W*g +: ROB_W];
    assign src1_arr[g] = bus.rs_src1[XLEN*g +: XLEN];
    assign src2_arr[g] = bus.rs_src2[XLEN*g +: XLEN];
  end

  logic             e1_valid;
  alu_op_e          e1_op;
  logic [ROB_W-1:0] e1_rob;
  logic [XLEN-1:0]  e1_src1;
  logic [XLEN-1:0]  e1_src2;
  logic             e2_valid;
  logic [ROB_W-1:0] e2_rob;
  logic [XLEN-1:0]  e2_result;
  logic [PTR_W-1:0] rr_ptr;

  logic             found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             e2_adv;
  logic             e1_move;
  logic             issue;
  logic [XLEN-1:0]  alu_result;
  logic [4:0]       shamt;

  // Scan NUM_RS slots starting at rr_ptr; the first ready slot wins.
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] sel;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_RS;
      sel = PTR_W'(idx);
      if (!found && bus.rs_valid[sel]) begin
        found   = 1'b1;
        win_idx = sel;
      end
    end
  end

  assign next_ptr = (win_idx == PTR_W'(NUM_RS - 1)) ? '0 : win_idx + 1'b1;
  assign e2_adv   = !e2_valid || bus.cdb_grant;
  assign e1_move  = e1_valid && e2_adv;
  assign issue    = found && (!e1_valid || e1_move) && !bus.mispredicted && !reset;

  always_comb begin
    bus.consumed = '0;
    if (issue) bus.consumed[win_idx] = 1'b1;
  end

  assign shamt = e1_src2[4:0];

  always_comb begin
    alu_result = '0;
    case (e1_op)
      OP_ADD:  alu_result = e1_src1 + e1_src2;
      OP_SUB:  alu_result = e1_src1 - e1_src2;
      OP_AND:  alu_result = e1_src1 & e1_src2;
      OP_OR:   alu_result = e1_src1 | e1_src2;
      OP_XOR:  alu_result = e1_src1 ^ e1_src2;
      OP_SLL:  alu_result = e1_src1 << shamt;
      OP_SRL:  alu_result = e1_src1 >> shamt;
      OP_SLT:  alu_result = XLEN'($signed(e1_src1) < $signed(e1_src2));
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e1_valid  <= 1'b0;
      e1_op     <= OP_ADD;
      e1_rob    <= '0;
      e1_src1   <= '0;
      e1_src2   <= '0;
      e2_valid  <= 1'b0;
      e2_rob    <= '0;
      e2_result <= '0;
      rr_ptr    <= '0;
    end else if (bus.mispredicted) begin
      // Flush drops both stages; rr_ptr is architectural fairness state and survives.
      e1_valid <= 1'b0;
      e2_valid <= 1'b0;
    end else begin
      if (e2_adv) begin
        e2_valid <= e1_valid;
        if (e1_valid) begin
          e2_rob    <= e1_rob;
          e2_result <= alu_result;
        end
      end
      if (issue) begin
        e1_valid <= 1'b1;
        e1_op    <= alu_op_e'(op_arr[win_idx]);
        e1_rob   <= rob_arr[win_idx];
        e1_src1  <= src1_arr[win_idx];
        e1_src2  <= src2_arr[win_idx];
        rr_ptr   <= next_ptr;
      end else if (e1_move) begin
        e1_valid <= 1'b0;
      end
    end
  end

  assign bus.cdb_req    = e2_valid;
  assign bus.cdb_rob    = e2_valid ? e2_rob : '0;
  assign bus.cdb_result = e2_valid ? e2_result : '0;
  assign bus.unit_busy  = e1_valid || e2_valid;
endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameter: NUM_RS, 4, number of reservation stations arbitrated.
REQ-002 Parameter: XLEN, 32, operand and result width.
REQ-003 Parameter: ROB_W, 4, ROB tag width; tag 0 means "no entry".
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 mispredicted  in  1  pipeline flush.
REQ-007 rs_valid  in  NUM_RS  per-RS "operands ready and ROB tag nonzero".
REQ-008 rs_alu_op  in  3*NUM_RS  per-RS ALU opcode; slice i = bits [3i+2:3i].
REQ-009 rs_rob  in  ROB_W*NUM_RS  per-RS destination ROB tag.
REQ-010 rs_src1, rs_src2  in  XLEN*NUM_RS  per-RS operand values.
REQ-011 consumed  out  NUM_RS  one-hot pulse that clears the selected RS at the next edge.
REQ-012 cdb_req  out  1  result valid; requests the CDB.
REQ-013 cdb_grant  in  1  CDB arbiter accepts the result this cycle.
REQ-014 cdb_rob  out  ROB_W  ROB tag of the presented result.
REQ-015 cdb_result  out  XLEN  presented result.
REQ-016 unit_busy  out  1  high when either pipeline stage holds a valid op.

Function
REQ-017 Two register stages: E1 (captured operands, op, tag) and E2 (computed result, tag); each stage has a valid bit.
REQ-018 E2 advances when E2 is empty or when cdb_req & cdb_grant; E1 moves into E2 on any cycle E2 advances and E1 is valid.
REQ-019 Issue is enabled when E1 is empty or E1 moves this cycle; no issue otherwise.
REQ-020 Selection: round-robin over rs_valid, starting at rr_ptr; first set bit at or after rr_ptr (mod NUM_RS) wins.
REQ-021 rr_ptr resets to 0; after an issue from RS i, rr_ptr becomes (i+1) mod NUM_RS; unchanged when no issue.
REQ-022 consumed is combinational: it is one-hot on the winning index in the issue cycle and zero otherwise; never more than one bit set.
REQ-023 The issue cycle captures the winner's op, tag and operands into E1 at the same edge the RS clears.
REQ-024 ALU ops: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 slt (signed, result 1 or 0).
REQ-025 Shift amount = src2[4:0]; add/sub wrap modulo 2^XLEN; no overflow flag.
REQ-026 Result is computed from E1 contents and registered into E2; issue-to-cdb_req latency = 2 cycles when the CDB is uncontended.
REQ-027 cdb_req = E2 valid; cdb_rob and cdb_result hold stable while cdb_req is high without grant.
REQ-028 Throughput: one op per cycle sustained while cdb_grant is held high.
REQ-029 Back-pressure: with E1 and E2 full and no grant, consumed stays 0 and both stages hold.
REQ-030 mispredicted: at the next edge E1 and E2 are invalidated and rr_ptr is kept; consumed = 0 during the flush cycle; a grant in the flush cycle is ignored.
REQ-031 cdb_rob and cdb_result are 0 whenever cdb_req = 0.

Reset
REQ-032 reset has priority over mispredicted and all other inputs.
REQ-033 After reset: E1/E2 valid = 0, rr_ptr = 0, consumed = 0, cdb_req = 0, cdb_rob = 0, cdb_result = 0, unit_busy = 0.
REQ-034 Reset during back-pressure discards held results with no CDB transfer.

Verification
REQ-035 Single op: rs_valid = 0001, RS0 add 5+7 tag 3, grant held high -> consumed = 0001 in cycle 0; cdb_req with rob = 3, result = 12 in cycle 2; done in cycle 3.
REQ-036 Round-robin: rs_valid = 1111 held, grant high -> consumed sequence 0001, 0010, 0100, 1000, 0001.
REQ-037 Back-pressure: grant low for 4 cycles with RS ops pending -> two ops accepted, then consumed = 0; cdb outputs stable; releasing grant drains in order.
REQ-038 Flush: two ops in flight plus mispredicted -> cdb_req = 0 the next cycle, no CDB transfer, rr_ptr preserved.
REQ-039 ALU corners: sub 0-1 = FFFFFFFF; slt -1 vs 1 = 1; sll by 33 shifts by 1; srl 80000000 by 31 = 1.
REQ-040 Reset mid-stream while cdb_req is high -> every output is 0 the next cycle.
